// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// Module  : traffic_light_ctrl
// Brief   : Prescaled traffic-light sequencer with pedestrian walk phase and
//           emergency override.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module traffic_light_ctrl #(
    parameter int unsigned PRESCALE     = 6,
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned RED_TICKS    = 4,
    parameter int unsigned WALK_TICKS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] light,
    output logic       walk,
    output logic       phase_done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_GREEN  = 3'd0,
        S_YELLOW = 3'd1,
        S_RED    = 3'd2,
        S_WALK   = 3'd3,
        S_EMERG  = 3'd4
    } state_t;

    localparam logic [7:0] c_PRESC_LAST = 8'(PRESCALE - 1);

    state_t     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] tick_q, tick_d;
    logic       ped_q, ped_d;
    logic       pd_q, pd_d;
    logic [2:0] light_q;
    logic       walk_q;

    logic       w_tick;
    logic       w_last;

    function automatic logic [7:0] dur_of(input state_t s);
        case (s)
            S_GREEN:  dur_of = 8'(GREEN_TICKS);
            S_YELLOW: dur_of = 8'(YELLOW_TICKS);
            S_WALK:   dur_of = 8'(WALK_TICKS);
            default:  dur_of = 8'(RED_TICKS);
        endcase
    endfunction

    function automatic logic [2:0] light_of(input state_t s);
        case (s)
            S_GREEN:  light_of = 3'b001;
            S_YELLOW: light_of = 3'b010;
            default:  light_of = 3'b100;
        endcase
    endfunction

    assign w_tick = (presc_q == c_PRESC_LAST);
    assign w_last = (tick_q == (dur_of(state_q) - 8'd1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        pd_d    = 1'b0;
        ped_d   = ped_q | (ped_req && (state_q != S_WALK));

        if (emerg) begin
            state_d = S_EMERG;
            presc_d = 8'd0;
            tick_d  = 8'd0;
        end else begin
            case (state_q)
                S_GREEN, S_YELLOW, S_RED, S_WALK: begin
                    if (enable) begin
                        if (w_tick) begin
                            presc_d = 8'd0;
                            if (w_last) begin
                                tick_d = 8'd0;
                                pd_d   = 1'b1;
                                case (state_q)
                                    S_GREEN:  state_d = S_YELLOW;
                                    S_YELLOW: state_d = S_RED;
                                    S_RED:    state_d = ped_q ? S_WALK : S_GREEN;
                                    default:  state_d = S_GREEN;
                                endcase
                            end else begin
                                tick_d = tick_q + 8'd1;
                            end
                        end else begin
                            presc_d = presc_q + 8'd1;
                        end
                    end
                end
                // EMERG release and any corrupted code both restart a clean RED
                default: begin
                    state_d = S_RED;
                    presc_d = 8'd0;
                    tick_d  = 8'd0;
                end
            endcase
        end

        // Entering WALK consumes the request, even one arriving this cycle
        if ((state_d == S_WALK) && (state_q != S_WALK)) begin
            ped_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RED;
            presc_q <= 8'd0;
            tick_q  <= 8'd0;
            ped_q   <= 1'b0;
            pd_q    <= 1'b0;
            light_q <= 3'b100;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            ped_q   <= ped_d;
            pd_q    <= pd_d;
            light_q <= light_of(state_d);
            walk_q  <= (state_d == S_WALK);
        end
    end

    assign light      = light_q;
    assign walk       = walk_q;
    assign phase_done = pd_q;
    assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ============================================================================
// Module  : tb_traffic_light_ctrl
// Brief   : Directed self-checking bench for traffic_light_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl;

    localparam logic [2:0] c_GREEN  = 3'd0;
    localparam logic [2:0] c_YELLOW = 3'd1;
    localparam logic [2:0] c_RED    = 3'd2;
    localparam logic [2:0] c_WALK   = 3'd3;
    localparam logic [2:0] c_EMERG  = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [2:0] light, light2;
    logic       walk, walk2;
    logic       pd, pd2;
    logic [2:0] st, st2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl u_dut (
        .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req), .emerg(emerg),
        .light(light), .walk(walk), .phase_done(pd), .state(st)
    );

    traffic_light_ctrl #(
        .PRESCALE(1), .GREEN_TICKS(1), .YELLOW_TICKS(1), .RED_TICKS(1), .WALK_TICKS(1)
    ) u_dut_fast (
        .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req), .emerg(emerg),
        .light(light2), .walk(walk2), .phase_done(pd2), .state(st2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called at a negedge inside a phase already `start` cycles old; returns at
    // the first negedge of the following phase.
    task automatic phase(input string tag, input int start, input int exp_len,
                         input logic [2:0] exp_nxt, input logic exp_pd);
        logic [2:0] cur;
        int len;
        int extra;
        cur   = st;
        len   = start;
        extra = 0;
        do begin
            @(negedge clk);
            if (st == cur) begin
                len++;
                if (pd) extra++;
            end
        end while ((st == cur) && (len < 400));
        check({tag, "_len"}, len, exp_len);
        check({tag, "_next"}, {29'd0, st}, {29'd0, exp_nxt});
        check({tag, "_pd_edge"}, {31'd0, pd}, {31'd0, exp_pd});
        check({tag, "_pd_extra"}, extra, 0);
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [2:0] fast_seq [0:5];
    int stall_bad;

    initial begin
        fast_seq[0] = c_GREEN;  fast_seq[1] = c_YELLOW; fast_seq[2] = c_RED;
        fast_seq[3] = c_GREEN;  fast_seq[4] = c_YELLOW; fast_seq[5] = c_RED;

        // Reset values
        wait_neg(3);
        check("rst_state", {29'd0, st}, {29'd0, c_RED});
        check("rst_light", {29'd0, light}, 32'd4);
        check("rst_walk", {31'd0, walk}, 0);
        check("rst_pd", {31'd0, pd}, 0);
        rst = 1'b0;

        // Free run
        phase("free_red", 1, 24, c_GREEN, 1'b1);
        check("free_green_light", {29'd0, light}, 32'd1);
        phase("free_green", 1, 30, c_YELLOW, 1'b1);
        check("free_yellow_light", {29'd0, light}, 32'd2);
        phase("free_yellow", 1, 12, c_RED, 1'b1);
        phase("free_red2", 1, 24, c_GREEN, 1'b1);

        // Pedestrian request in GREEN, another ignored in WALK
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        phase("ped_green", 2, 30, c_YELLOW, 1'b1);
        phase("ped_yellow", 1, 12, c_RED, 1'b1);
        phase("ped_red", 1, 24, c_WALK, 1'b1);
        check("walk_light", {29'd0, light}, 32'd4);
        check("walk_walk", {31'd0, walk}, 1);
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        phase("walk", 2, 18, c_GREEN, 1'b1);
        check("walk_off", {31'd0, walk}, 0);
        phase("ped2_green", 1, 30, c_YELLOW, 1'b1);
        phase("ped2_yellow", 1, 12, c_RED, 1'b1);
        phase("ped2_red", 1, 24, c_GREEN, 1'b1);

        // Enable stall mid-GREEN
        wait_neg(9);
        enable = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((st != c_GREEN) || (light != 3'b001)) stall_bad++;
        end
        check("stall_hold", stall_bad, 0);
        enable = 1'b1;
        phase("stall_green", 20, 40, c_YELLOW, 1'b1);

        // Emergency during YELLOW
        wait_neg(2);
        emerg = 1'b1;
        @(negedge clk);
        check("emerg_state", {29'd0, st}, {29'd0, c_EMERG});
        check("emerg_light", {29'd0, light}, 32'd4);
        check("emerg_pd", {31'd0, pd}, 0);
        wait_neg(4);
        emerg = 1'b0;
        @(negedge clk);
        check("emerg_rel_state", {29'd0, st}, {29'd0, c_RED});
        check("emerg_rel_pd", {31'd0, pd}, 0);
        phase("emerg_red", 1, 24, c_GREEN, 1'b1);

        // Emergency on the GREEN phase-end edge
        wait_neg(29);
        emerg = 1'b1;
        @(negedge clk);
        check("emerg_end_state", {29'd0, st}, {29'd0, c_EMERG});
        check("emerg_end_pd", {31'd0, pd}, 0);
        emerg = 1'b0;
        @(negedge clk);
        check("emerg_end_rel", {29'd0, st}, {29'd0, c_RED});
        check("emerg_end_rel_pd", {31'd0, pd}, 0);
        phase("emerg_end_red", 1, 24, c_GREEN, 1'b1);

        // Reset during WALK
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        phase("rw_green", 2, 30, c_YELLOW, 1'b1);
        phase("rw_yellow", 1, 12, c_RED, 1'b1);
        phase("rw_red", 1, 24, c_WALK, 1'b1);
        wait_neg(3);
        rst = 1'b1; ped_req = 1'b1;
        @(negedge clk);
        rst = 1'b0; ped_req = 1'b0;
        check("rw_state", {29'd0, st}, {29'd0, c_RED});
        check("rw_walk", {31'd0, walk}, 0);
        check("rw_light", {29'd0, light}, 32'd4);
        check("rw_pd", {31'd0, pd}, 0);
        phase("rw_after_red", 1, 24, c_GREEN, 1'b1);

        // Reset clears a pending request
        ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
        wait_neg(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        phase("rp_red", 1, 24, c_GREEN, 1'b1);

        // Minimum-duration corner on the fast instance
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("fast_rst_state", {29'd0, st2}, {29'd0, c_RED});
        check("fast_rst_pd", {31'd0, pd2}, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("fast_state_%0d", i), {29'd0, st2}, {29'd0, fast_seq[i]});
            check($sformatf("fast_pd_%0d", i), {31'd0, pd2}, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
